processor: RTL and testbench
============================

PROCESSOR -- requirements
Module: processor

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with the port order below.
- clk  input  1  – clock; all state updates on the rising edge.
- reset  input  1  – synchronous, active-high reset.
- pc  output  32  – current program counter (byte address); instruction memory reads the word at pc[8:2].
- instruction  input  32  – instruction word at pc, delivered combinationally.
- write_enable  output  1  – data memory write strobe; memory writes on the rising edge when high.
- address_to_mem  output  32  – data memory byte address; memory uses address[31:2].
- data_to_mem  output  32  – store data.
- data_from_mem  input  32  – load data, read combinationally at address_to_mem.

Function
REQ-003 The block SHALL be a single-cycle RV32I-subset core: one instruction per clk.
REQ-004 The block SHALL have 32×32 registers; x0 reads 0 and ignores writes; two combinational read ports; one write port written on the rising edge.
REQ-005 The block SHALL implement R-type add, sub, and, or, xor, slt, sltu, sll, srl, sra; shift amount = rs2[4:0]; sra arithmetic; slt signed; sltu unsigned.
REQ-006 The block SHALL implement I-type addi, andi, ori, xori, slti, slli, srli, srai with the 12-bit sign-extended immediate.
REQ-007 The block SHALL implement lw: rd = data_from_mem, address_to_mem = rs1 + imm_I.
REQ-008 The block SHALL implement sw: write_enable = 1, address_to_mem = rs1 + imm_S, data_to_mem = rs2.
- Only full-word access; address[1:0] ignored.
REQ-009 The block SHALL implement branches beq, bne, blt, bge, bltu, bgeu.
- Taken: pc_next = pc + imm_B.
- Not taken: pc_next = pc + 4.
REQ-010 The block SHALL implement jal: rd = pc + 4, pc_next = pc + imm_J.
REQ-011 The block SHALL implement jalr: rd = pc + 4, pc_next = (rs1 + imm_I) & ~1.
- rd is written after the target is computed from the old rs1, so rd == rs1 is correct.
REQ-012 The block SHALL implement lui (rd = imm_U) and auipc (rd = pc + imm_U), where imm_U = instr[31:12] << 12.
REQ-013 All arithmetic SHALL be 32-bit modulo 2^32; overflow is ignored.
REQ-014 Any unrecognised opcode or funct SHALL act as NOP: no register write, write_enable = 0, pc_next = pc + 4.
REQ-015 For non-store instructions, write_enable SHALL be 0.
- address_to_mem = ALU result.
- data_to_mem = rs2 value.
REQ-016 The pc register SHALL wrap modulo 2^32 with no fault, alignment or exception checks.

Reset
REQ-017 While reset = 1 at a rising edge, the block SHALL set pc to 0x00000000 and clear all registers to 0.
REQ-018 While reset = 1, write_enable SHALL be 0 and no register write SHALL occur.
REQ-019 After reset deasserts, the first instruction executed SHALL be the one at address 0.
REQ-020 Reset asserted mid-program SHALL abandon the current instruction with no memory write on that edge.

Verification
REQ-021 ALU test: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x1,x2 -> x3 = 2, x4 = 8; pc = 0x10 after 4 cycles.
REQ-022 Compare/shift test: x1 = -3, x2 = 5 -> slt = 1, sltu = 0; addi x5,x0,-16; srai x6,x5,2 -> x6 = 0xFFFFFFFC; srli x7,x5,2 -> x7 = 0x3FFFFFFC.
REQ-023 Memory test: x1 = 0x10, x2 = 0x1234; sw x2,4(x1) -> write_enable = 1, address_to_mem = 0x14, data_to_mem = 0x1234; then lw x3,4(x1) -> x3 = 0x1234.
REQ-024 Branch test: beq on equal operands at pc 0x20 with offset +8 -> pc = 0x28; bne on the same operands -> pc = 0x24; blt -1 vs 1 is taken; bltu is not taken.
REQ-025 Jump test: jal x1,+12 at 0x40 -> x1 = 0x44, pc = 0x4C; jalr x0,0(x1) -> pc = 0x44; lui x5,0x12345 -> x5 = 0x12345000; auipc x6,1 at 0x50 -> x6 = 0x1050.
REQ-026 Reset/x0 test: addi x0,x0,7 leaves x0 = 0; reset asserted during sw -> no write, pc = 0 next cycle.

Source files
------------

// File: rtl/processor.sv
// ==================================================================
// processor : single-cycle RV32I-subset core, one instruction per clk
// rev 1.0
// ==================================================================
`default_nettype none

module processor (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic        write_enable,
  output logic [31:0] address_to_mem,
  output logic [31:0] data_to_mem,
  input  logic [31:0] data_from_mem
);

  localparam logic [6:0] c_op_reg    = 7'h33;
  localparam logic [6:0] c_op_imm    = 7'h13;
  localparam logic [6:0] c_op_load   = 7'h03;
  localparam logic [6:0] c_op_store  = 7'h23;
  localparam logic [6:0] c_op_branch = 7'h63;
  localparam logic [6:0] c_op_jal    = 7'h6f;
  localparam logic [6:0] c_op_jalr   = 7'h67;
  localparam logic [6:0] c_op_lui    = 7'h37;
  localparam logic [6:0] c_op_auipc  = 7'h17;

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [32];
  logic        rf_we_d;
  logic [31:0] rf_wdata_d;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] pc_plus4;
  logic [2:0]  alu_f3;
  logic        alu_alt;
  logic [31:0] alu_b, alu_res;
  logic        is_store, branch_taken;

  assign opcode   = instruction[6:0];
  assign rd       = instruction[11:7];
  assign funct3   = instruction[14:12];
  assign rs1      = instruction[19:15];
  assign rs2      = instruction[24:20];
  assign funct7   = instruction[31:25];
  assign rs1_val  = regs_q[rs1];
  assign rs2_val  = regs_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};

  // funct3-indexed ALU; alt selects sub / arithmetic right shift
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0:    r = alt ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'b0, $signed(a) < $signed(b)};
      3'd3:    r = {31'b0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_comb begin
    alu_f3  = funct3;
    alu_alt = 1'b0;
    alu_b   = rs2_val;
    case (opcode)
      c_op_reg: alu_alt = funct7[5];
      c_op_imm: begin
        alu_b   = imm_i;
        alu_alt = (funct3 == 3'd5) && funct7[5];
      end
      c_op_load, c_op_jalr: begin
        alu_f3 = 3'd0;
        alu_b  = imm_i;
      end
      c_op_store: begin
        alu_f3 = 3'd0;
        alu_b  = imm_s;
      end
      default: ;
    endcase
  end

  assign alu_res = alu(alu_f3, alu_alt, rs1_val, alu_b);

  always_comb begin
    case (funct3)
      3'd0:    branch_taken = rs1_val == rs2_val;
      3'd1:    branch_taken = rs1_val != rs2_val;
      3'd4:    branch_taken = $signed(rs1_val) <  $signed(rs2_val);
      3'd5:    branch_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'd6:    branch_taken = rs1_val <  rs2_val;
      3'd7:    branch_taken = rs1_val >= rs2_val;
      default: branch_taken = 1'b0;
    endcase
  end

  // Anything not explicitly decoded falls through as a NOP
  always_comb begin
    pc_d       = pc_plus4;
    rf_we_d    = 1'b0;
    rf_wdata_d = alu_res;
    is_store   = 1'b0;
    case (opcode)
      c_op_reg:
        rf_we_d = (funct7 == 7'h00) ||
                  (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
      c_op_imm:
        case (funct3)
          3'd1:    rf_we_d = funct7 == 7'h00;
          3'd3:    rf_we_d = 1'b0;
          3'd5:    rf_we_d = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: rf_we_d = 1'b1;
        endcase
      c_op_load: begin
        rf_we_d    = funct3 == 3'd2;
        rf_wdata_d = data_from_mem;
      end
      c_op_store: is_store = funct3 == 3'd2;
      c_op_branch:
        if (branch_taken) pc_d = pc_q + imm_b;
      c_op_jal: begin
        rf_we_d    = 1'b1;
        rf_wdata_d = pc_plus4;
        pc_d       = pc_q + imm_j;
      end
      c_op_jalr:
        if (funct3 == 3'd0) begin
          rf_we_d    = 1'b1;
          rf_wdata_d = pc_plus4;
          pc_d       = {alu_res[31:1], 1'b0};
        end
      c_op_lui: begin
        rf_we_d    = 1'b1;
        rf_wdata_d = imm_u;
      end
      c_op_auipc: begin
        rf_we_d    = 1'b1;
        rf_wdata_d = pc_q + imm_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'h0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else begin
      pc_q <= pc_d;
      if (rf_we_d && rd != 5'd0) regs_q[rd] <= rf_wdata_d;
    end
  end

  assign pc             = pc_q;
  assign write_enable   = is_store && !reset;
  assign address_to_mem = alu_res;
  assign data_to_mem    = rs2_val;

endmodule

`default_nettype wire

// File: tb/tb_processor.sv
// ==================================================================
// tb_processor : directed programs for processor with hand-computed results
// rev 1.0
// ==================================================================
`default_nettype none

module tb_processor;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        write_enable;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;

  logic [31:0] imem [128];
  logic [31:0] dmem [128];
  int          wr_count = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  processor dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .instruction    (instruction),
    .write_enable   (write_enable),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction   = imem[pc[8:2]];
  assign data_from_mem = dmem[address_to_mem[8:2]];

  always @(posedge clk) begin
    if (write_enable) begin
      dmem[address_to_mem[8:2]] <= data_to_mem;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_nops();
    for (int k = 0; k < 128; k++) imem[k] = 32'h0000_0013;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check("rst_we", {31'b0, write_enable}, 32'h0);
    check("rst_pc", pc, 32'h0);
    reset = 1'b0;
    #1;
  endtask

  task automatic expect_store(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_we"}, {31'b0, write_enable}, 32'h1);
    check({tag, "_addr"}, address_to_mem, addr);
    check({tag, "_data"}, data_to_mem, data);
    step();
  endtask

  logic [2:0]  br_f3  [9] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd0, 3'd1, 3'd2};
  logic [31:0] br_a   [9] = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1};
  logic [31:0] br_b   [9] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd1};
  logic [31:0] br_off [9] = '{32'd8, 32'd8, 32'd8, 32'd8, 32'd8, 32'd8,
                              32'hFFFF_FFF8, 32'd12, 32'd8};
  logic [31:0] br_exp [9] = '{32'h28, 32'h24, 32'h28, 32'h24, 32'h24, 32'h28,
                              32'h18, 32'h2C, 32'h24};

  logic [4:0]  cs_reg [10] = '{5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
  logic [31:0] cs_exp [10] = '{32'h1, 32'h0, 32'hFFFF_FFFC, 32'h3FFF_FFFC, 32'hFFFF_FFF8,
                               32'hFFFF_FFFF, 32'hA0, 32'hFFFF_FFD0, 32'hD, 32'h35};

  initial begin
    int wr_before;
    reset = 1'b1;

    // ALU basics plus NOP handling of unknown opcode and unsupported funct7
    load_nops();
    imem[0] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 32'd5);
    imem[1] = enc_i(7'h13, 3'd0, 5'd2, 5'd0, 32'hFFFF_FFFD);
    imem[2] = enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2);
    imem[3] = enc_r(7'h20, 3'd0, 5'd4, 5'd1, 5'd2);
    imem[4] = enc_s(5'd3, 5'd0, 32'd0);
    imem[5] = enc_s(5'd4, 5'd0, 32'd4);
    imem[6] = 32'h0000_007F;
    imem[7] = enc_r(7'h01, 3'd0, 5'd3, 5'd1, 5'd2);
    imem[8] = enc_s(5'd3, 5'd0, 32'd8);
    do_reset();
    repeat (4) step();
    check("alu_pc", pc, 32'h10);
    expect_store("add", 32'h0, 32'h2);
    expect_store("sub", 32'h4, 32'h8);
    check("badop_we", {31'b0, write_enable}, 32'h0);
    step();
    check("badop_pc", pc, 32'h1C);
    step();
    expect_store("badf7", 32'h8, 32'h2);

    // Compare, shift and logic operations
    load_nops();
    imem[0]  = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 32'hFFFF_FFFD);
    imem[1]  = enc_i(7'h13, 3'd0, 5'd2, 5'd0, 32'd5);
    imem[2]  = enc_r(7'h00, 3'd2, 5'd3, 5'd1, 5'd2);
    imem[3]  = enc_r(7'h00, 3'd3, 5'd4, 5'd1, 5'd2);
    imem[4]  = enc_i(7'h13, 3'd0, 5'd5, 5'd0, 32'hFFFF_FFF0);
    imem[5]  = enc_i(7'h13, 3'd5, 5'd6, 5'd5, 32'h402);
    imem[6]  = enc_i(7'h13, 3'd5, 5'd7, 5'd5, 32'h002);
    imem[7]  = enc_r(7'h00, 3'd4, 5'd8, 5'd1, 5'd2);
    imem[8]  = enc_r(7'h20, 3'd5, 5'd9, 5'd5, 5'd2);
    imem[9]  = enc_r(7'h00, 3'd1, 5'd10, 5'd2, 5'd2);
    imem[10] = enc_i(7'h13, 3'd1, 5'd11, 5'd1, 32'd4);
    imem[11] = enc_i(7'h13, 3'd7, 5'd12, 5'd1, 32'hF);
    imem[12] = enc_i(7'h13, 3'd6, 5'd13, 5'd2, 32'h30);
    for (int k = 0; k < 10; k++) imem[13 + k] = enc_s(cs_reg[k], 5'd0, 32'd0);
    do_reset();
    repeat (13) step();
    for (int k = 0; k < 10; k++) begin
      check("cmpshift", data_to_mem, cs_exp[k]);
      step();
    end

    // Store then load the same word
    load_nops();
    imem[0] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 32'h10);
    imem[1] = enc_u(7'h37, 5'd2, 20'h00001);
    imem[2] = enc_i(7'h13, 3'd0, 5'd2, 5'd2, 32'h234);
    imem[3] = enc_s(5'd2, 5'd1, 32'd4);
    imem[4] = enc_i(7'h03, 3'd2, 5'd3, 5'd1, 32'd4);
    imem[5] = enc_s(5'd3, 5'd0, 32'd0);
    do_reset();
    repeat (3) step();
    expect_store("sw", 32'h14, 32'h1234);
    check("lw_we", {31'b0, write_enable}, 32'h0);
    check("lw_addr", address_to_mem, 32'h14);
    step();
    expect_store("lw", 32'h0, 32'h1234);

    // Branches: operands in x1/x2, branch placed at 0x20
    for (int v = 0; v < 9; v++) begin
      load_nops();
      imem[0] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, br_a[v]);
      imem[1] = enc_i(7'h13, 3'd0, 5'd2, 5'd0, br_b[v]);
      imem[8] = enc_b(br_f3[v], 5'd1, 5'd2, br_off[v]);
      do_reset();
      repeat (8) step();
      check("br_at", pc, 32'h20);
      step();
      check("br_pc", pc, br_exp[v]);
    end

    // Jumps and upper-immediate ops
    load_nops();
    imem[0]  = enc_j(5'd0, 32'h40);
    imem[16] = enc_j(5'd1, 32'd12);
    imem[17] = enc_s(5'd1, 5'd0, 32'd0);
    imem[18] = enc_j(5'd0, 32'd8);
    imem[19] = enc_i(7'h67, 3'd0, 5'd0, 5'd1, 32'd0);
    imem[20] = enc_u(7'h17, 5'd6, 20'h00001);
    imem[21] = enc_u(7'h37, 5'd5, 20'h12345);
    imem[22] = enc_s(5'd6, 5'd0, 32'd0);
    imem[23] = enc_s(5'd5, 5'd0, 32'd0);
    imem[24] = enc_i(7'h13, 3'd0, 5'd7, 5'd0, 32'h71);
    imem[25] = enc_i(7'h67, 3'd0, 5'd7, 5'd7, 32'd0);
    imem[28] = enc_s(5'd7, 5'd0, 32'd0);
    do_reset();
    step();
    check("jal0_pc", pc, 32'h40);
    step();
    check("jal_pc", pc, 32'h4C);
    step();
    check("jalr_pc", pc, 32'h44);
    expect_store("jal_link", 32'h0, 32'h44);
    check("jal2_pc", pc, 32'h48);
    step();
    check("auipc_at", pc, 32'h50);
    step();
    step();
    expect_store("auipc", 32'h0, 32'h1050);
    expect_store("lui", 32'h0, 32'h1234_5000);
    step();
    step();
    check("jalr_same_pc", pc, 32'h70);
    expect_store("jalr_same_link", 32'h0, 32'h68);

    // x0 stays zero; reset during a store suppresses the write
    load_nops();
    imem[0] = enc_i(7'h13, 3'd0, 5'd0, 5'd0, 32'd7);
    imem[1] = enc_s(5'd0, 5'd0, 32'd0);
    imem[2] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 32'd9);
    imem[3] = enc_s(5'd1, 5'd0, 32'd8);
    do_reset();
    step();
    expect_store("x0", 32'h0, 32'h0);
    step();
    check("pre_rst_we", {31'b0, write_enable}, 32'h1);
    wr_before = wr_count;
    reset = 1'b1;
    #1;
    check("in_rst_we", {31'b0, write_enable}, 32'h0);
    step();
    check("rst_no_write", wr_count, wr_before);
    check("rst_mid_pc", pc, 32'h0);
    imem[0] = enc_s(5'd1, 5'd0, 32'd0);
    reset = 1'b0;
    #1;
    expect_store("rf_cleared", 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
